camera_qsys_timed_pio: RTL and testbench
========================================

// Module: camera_qsys_timed_pio
// PURPOSE
//   Avalon-MM slave output port, generalised successor of the single-bit camera PIOs
//   (pwdn_n, reset_n). WIDTH-bit output plus a one-shot down-counter that inverts a
//   programmed bit mask N clocks after arming. This gives hardware-timed camera
//   power-up/reset sequencing without CPU busy-wait. Sits in camera_qsys on the HPS/Nios bus.
// PARAMETERS
//   WIDTH        4   output bits, 1..32
//   RESET_VALUE  1   out_port value at reset (low WIDTH bits used)
//   CNT_W        24  timer counter width, 1..32
// PORTS
//   clk         in   1      system clock, single clock domain
//   reset_n     in   1      asynchronous, active-low reset
//   address     in   2      word address: 0 DATA, 1 MASK, 2 TIMER, 3 STATUS
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data; bits above WIDTH/CNT_W ignored
//   readdata    out  32     combinational read data, zero-extended
//   out_port    out  WIDTH  registered output (= DATA)
//   irq         out  1      expiry interrupt, only with CAM_PIO_IRQ_EN
// BEHAVIOUR
//   - Write accepted on the rising edge where chipselect=1 and write_n=0. No wait states.
//     Reads have zero latency; readdata decodes combinationally from address.
//   - Reset (async assert, sync release): data=RESET_VALUE, mask=0, count=0, busy=0, irq=0.
//     Reset mid-countdown abandons it; no toggle occurs.
//   - DATA (0): R/W. out_port updates on the accepting edge.
//   - MASK (1): R/W, WIDTH bits. These bits are inverted at timer expiry.
//   - TIMER (2): write N != 0 loads count=N and sets busy=1. Write N=0 cancels:
//     count=0, busy=0, no toggle, no irq.
//     A write while busy restarts with the new N; the old countdown is discarded.
//     Read returns remaining count.
//   - Countdown: while busy, count decrements once per clk. On the edge where count
//     goes 1->0: data <= data ^ mask, busy <= 0, irq event.
//     Net effect: out_port toggles on the Nth edge after the TIMER write edge.
//     Every cycle is counted; there is no prescaler.
//   - MASK is sampled at the expiry edge. It may be changed during the countdown.
//   - Simultaneous events:
//       DATA write on the expiry edge: the CPU value wins (data=writedata), busy still clears,
//       irq still sets.
//       MASK write on the expiry edge: the old mask is applied.
//       TIMER write on the expiry edge: the toggle is applied and the new countdown loads.
//   - STATUS (3): read bit0=busy, bit1=irq_pending, others 0.
//     Write bit1=1 clears irq_pending; write bit2=1 aborts like TIMER=0. Other bits ignored.
//   - irq_pending sets on expiry and holds until cleared. If set and clear occur on the same
//     edge, set wins.
//   - Writes to bits outside WIDTH/CNT_W have no effect. Reads of those bits return 0.
//   - No counter wrap: count saturates at 0, and busy=0 stops decrementing.
// CONFIGURATION
//   CAM_PIO_IRQ_EN defined: irq port present, irq = irq_pending (registered, level).
//   CAM_PIO_IRQ_EN undefined: no irq port. STATUS bit1 still reflects expiry and is
//   clearable, for polling.
// TESTING
//   1 Reset, then read all addresses -> out_port=0x1, DATA=0x1, MASK=0, TIMER=0, STATUS=0.
//   2 Write DATA=0xFFFFFFF5 -> out_port=0x5 on the next edge; read DATA=0x00000005.
//   3 DATA=0x1, MASK=0x3, TIMER=5 -> TIMER reads 5,4,3,2,1; out_port=0x2 on the 5th edge;
//     STATUS=0x2.
//   4 TIMER=10, then STATUS write 0x4 at remaining 4 -> busy=0, out_port unchanged, irq stays 0.
//   5 TIMER=3, then DATA=0x8 on the expiry edge -> out_port=0x8, busy=0, irq_pending=1.
//   6 Expiry, then STATUS write 0x2 -> irq 1->0 next edge.
//     Separately: reset_n low mid-countdown -> out_port=0x1 immediately, no later toggle.

Source files
------------

// File: rtl/camera_qsys_timed_pio_if.sv
// Avalon-MM slave bus bundle for camera_qsys_timed_pio.
// The master modport is the bus host (CPU/testbench); the slave modport is the PIO.
interface camera_qsys_timed_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/camera_qsys_timed_pio.sv
// camera_qsys_timed_pio: Avalon-MM output port with a one-shot down-counter.
// The counter inverts the programmed MASK bits of DATA N clocks after TIMER is
// written, giving hardware-timed camera power-up/reset sequencing.
// Register map: 0 DATA, 1 MASK, 2 TIMER (remaining count), 3 STATUS {irq_pending, busy}.
// Optional feature macro: CAM_PIO_IRQ_EN adds the level irq output (= irq_pending).
module camera_qsys_timed_pio #(
    parameter int          WIDTH       = 4,
    parameter logic [31:0] RESET_VALUE = 32'd1,
    parameter int          CNT_W       = 24
) (
    input  logic                      clk,
    input  logic                      reset_n,
    camera_qsys_timed_pio_if.slave    bus,
    output logic [WIDTH-1:0]          out_port
`ifdef CAM_PIO_IRQ_EN
    ,
    output logic                      irq
`endif
);

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] mask_r;
    logic [CNT_W-1:0] count_r;
    logic             busy_r;
    logic             irq_pending_r;

    logic             wr_s;
    logic             wr_data_s;
    logic             wr_mask_s;
    logic             wr_timer_s;
    logic             wr_status_s;
    logic             expire_s;
    logic             abort_s;
    logic [CNT_W-1:0] new_count_s;
    logic [31:0]      readdata_s;
    logic             unused_wdata_s;

    // Bus write decode; the expiry edge is the one where the count leaves 1.
    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign wr_data_s   = wr_s && (bus.address == 2'd0);
    assign wr_mask_s   = wr_s && (bus.address == 2'd1);
    assign wr_timer_s  = wr_s && (bus.address == 2'd2);
    assign wr_status_s = wr_s && (bus.address == 2'd3);
    assign new_count_s = bus.writedata[CNT_W-1:0];
    assign abort_s     = wr_status_s && bus.writedata[2];
    assign expire_s    = busy_r && (count_r == CNT_W'(1));

    // Bits of writedata beyond WIDTH/CNT_W and the unused STATUS bits are ignored.
    assign unused_wdata_s = ^bus.writedata;

    // DATA: a CPU write wins over the expiry toggle on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= RESET_VALUE[WIDTH-1:0];
        end else if (wr_data_s) begin
            data_r <= bus.writedata[WIDTH-1:0];
        end else if (expire_s) begin
            data_r <= data_r ^ mask_r;
        end else begin
            data_r <= data_r;
        end
    end

    // MASK: the expiry uses the registered (old) value even if rewritten on that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r <= {WIDTH{1'b0}};
        end else if (wr_mask_s) begin
            mask_r <= bus.writedata[WIDTH-1:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    // One-shot countdown: TIMER write loads/restarts or cancels, STATUS bit2 aborts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else if (wr_timer_s) begin
            count_r <= new_count_s;
            busy_r  <= (new_count_s != {CNT_W{1'b0}});
        end else if (abort_s) begin
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else if (busy_r && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
            busy_r  <= !expire_s;
        end else begin
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end
    end

    // Sticky expiry flag: set has priority over a same-edge clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending_r <= 1'b0;
        end else if (expire_s) begin
            irq_pending_r <= 1'b1;
        end else if (wr_status_s && bus.writedata[1]) begin
            irq_pending_r <= 1'b0;
        end else begin
            irq_pending_r <= irq_pending_r;
        end
    end

    // Zero-latency read mux, zero-extended to 32 bits.
    always_comb begin
        readdata_s = 32'd0;
        case (bus.address)
            2'd0:    readdata_s[WIDTH-1:0] = data_r;
            2'd1:    readdata_s[WIDTH-1:0] = mask_r;
            2'd2:    readdata_s[CNT_W-1:0] = count_r;
            2'd3:    readdata_s[1:0]       = {irq_pending_r, busy_r};
            default: readdata_s            = 32'd0;
        endcase
    end

    assign bus.readdata = readdata_s;
    assign out_port     = data_r;

`ifdef CAM_PIO_IRQ_EN
    assign irq = irq_pending_r;
`endif

endmodule

// File: tb/tb_camera_qsys_timed_pio.sv
// Directed table-driven bench for camera_qsys_timed_pio (default parameters).
// Each table row occupies exactly one rising clock edge: an optional write on that
// edge, then a read of one address plus out_port, compared against hand-derived values.
module tb_camera_qsys_timed_pio;

    logic       clk;
    logic       reset_n;
    logic [3:0] out_port;
`ifdef CAM_PIO_IRQ_EN
    logic       irq;
`endif

    camera_qsys_timed_pio_if bus ();

    camera_qsys_timed_pio dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
`ifdef CAM_PIO_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic [3:0]  exp_out;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t wr(input logic [1:0] wa, input logic [31:0] wd,
                                input logic [1:0] ra, input logic [31:0] rd, input logic [3:0] o);
        vec_t v;
        v = '{do_wr: 1'b1, waddr: wa, wdata: wd, raddr: ra, exp_rd: rd, exp_out: o};
        return v;
    endfunction

    function automatic vec_t idle(input logic [1:0] ra, input logic [31:0] rd, input logic [3:0] o);
        vec_t v;
        v = '{do_wr: 1'b0, waddr: 2'd0, wdata: 32'd0, raddr: ra, exp_rd: rd, exp_out: o};
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        bus.chipselect = v.do_wr;
        bus.write_n    = ~v.do_wr;
        bus.address    = v.do_wr ? v.waddr : v.raddr;
        bus.writedata  = v.wdata;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = v.raddr;
        #1;
        check($sformatf("vec%0d_rd_a%0d", idx, v.raddr), bus.readdata, v.exp_rd);
        check($sformatf("vec%0d_out", idx), {28'd0, out_port}, {28'd0, v.exp_out});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;

        // Reset state
        vecs.push_back(idle(2'd0, 32'h1, 4'h1));
        vecs.push_back(idle(2'd1, 32'h0, 4'h1));
        vecs.push_back(idle(2'd2, 32'h0, 4'h1));
        vecs.push_back(idle(2'd3, 32'h0, 4'h1));
        // DATA write with upper bits ignored
        vecs.push_back(wr(2'd0, 32'hFFFF_FFF5, 2'd0, 32'h5, 4'h5));
        // Basic timed toggle: DATA=1, MASK=3, TIMER=5
        vecs.push_back(wr(2'd0, 32'h1, 2'd0, 32'h1, 4'h1));
        vecs.push_back(wr(2'd1, 32'h3, 2'd1, 32'h3, 4'h1));
        vecs.push_back(wr(2'd2, 32'd5, 2'd2, 32'd5, 4'h1));
        vecs.push_back(idle(2'd2, 32'd4, 4'h1));
        vecs.push_back(idle(2'd2, 32'd3, 4'h1));
        vecs.push_back(idle(2'd2, 32'd2, 4'h1));
        vecs.push_back(idle(2'd2, 32'd1, 4'h1));
        vecs.push_back(idle(2'd3, 32'h2, 4'h2));
        vecs.push_back(idle(2'd2, 32'd0, 4'h2));
        vecs.push_back(wr(2'd3, 32'h2, 2'd3, 32'h0, 4'h2));
        // Abort at remaining 4: no toggle, no irq
        vecs.push_back(wr(2'd2, 32'd10, 2'd2, 32'd10, 4'h2));
        for (int i = 9; i >= 4; i--) vecs.push_back(idle(2'd2, 32'(i), 4'h2));
        vecs.push_back(wr(2'd3, 32'h4, 2'd3, 32'h0, 4'h2));
        for (int i = 0; i < 3; i++) vecs.push_back(idle(2'd3, 32'h0, 4'h2));
        // DATA write on the expiry edge wins; busy clears, irq sets
        vecs.push_back(wr(2'd2, 32'd3, 2'd2, 32'd3, 4'h2));
        vecs.push_back(idle(2'd2, 32'd2, 4'h2));
        vecs.push_back(idle(2'd2, 32'd1, 4'h2));
        vecs.push_back(wr(2'd0, 32'h8, 2'd3, 32'h2, 4'h8));
        vecs.push_back(idle(2'd0, 32'h8, 4'h8));
        vecs.push_back(wr(2'd3, 32'h2, 2'd3, 32'h0, 4'h8));
        // Set wins over same-edge clear
        vecs.push_back(wr(2'd0, 32'h0, 2'd0, 32'h0, 4'h0));
        vecs.push_back(wr(2'd2, 32'd2, 2'd2, 32'd2, 4'h0));
        vecs.push_back(idle(2'd2, 32'd1, 4'h0));
        vecs.push_back(wr(2'd3, 32'h2, 2'd3, 32'h2, 4'h3));
        vecs.push_back(wr(2'd3, 32'h2, 2'd3, 32'h0, 4'h3));
        // MASK write on the expiry edge: old mask applied
        vecs.push_back(wr(2'd2, 32'd1, 2'd2, 32'd1, 4'h3));
        vecs.push_back(wr(2'd1, 32'hC, 2'd1, 32'hC, 4'h0));
        vecs.push_back(wr(2'd3, 32'h2, 2'd3, 32'h0, 4'h0));
        // TIMER write on the expiry edge: toggle applied and new countdown loads
        vecs.push_back(wr(2'd2, 32'd1, 2'd2, 32'd1, 4'h0));
        vecs.push_back(wr(2'd2, 32'd2, 2'd3, 32'h3, 4'hC));
        vecs.push_back(idle(2'd2, 32'd1, 4'hC));
        vecs.push_back(idle(2'd3, 32'h2, 4'h0));
        // Restart while busy discards the old countdown
        vecs.push_back(wr(2'd2, 32'd4, 2'd2, 32'd4, 4'h0));
        vecs.push_back(wr(2'd2, 32'd2, 2'd2, 32'd2, 4'h0));
        vecs.push_back(idle(2'd2, 32'd1, 4'h0));
        vecs.push_back(idle(2'd3, 32'h2, 4'hC));
        // TIMER=0 cancels
        vecs.push_back(wr(2'd3, 32'h2, 2'd3, 32'h0, 4'hC));
        vecs.push_back(wr(2'd2, 32'd2, 2'd2, 32'd2, 4'hC));
        vecs.push_back(wr(2'd2, 32'd0, 2'd3, 32'h0, 4'hC));
        vecs.push_back(idle(2'd3, 32'h0, 4'hC));
        vecs.push_back(idle(2'd3, 32'h0, 4'hC));
        // Out-of-range bits ignored on writes and read as zero
        vecs.push_back(wr(2'd1, 32'hFFFF_FFFF, 2'd1, 32'hF, 4'hC));
        vecs.push_back(wr(2'd2, 32'hFF00_0003, 2'd2, 32'd3, 4'hC));
        vecs.push_back(wr(2'd3, 32'hFFFF_FFFC, 2'd3, 32'h0, 4'hC));
        vecs.push_back(idle(2'd2, 32'd0, 4'hC));

        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'd0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

`ifdef CAM_PIO_IRQ_EN
        // irq level follows irq_pending
        run_vec(1000, wr(2'd2, 32'd1, 2'd3, 32'h1, 4'hC));
        run_vec(1001, idle(2'd3, 32'h2, 4'h3));
        check("irq_set", {31'd0, irq}, 32'd1);
        run_vec(1002, wr(2'd3, 32'h2, 2'd3, 32'h0, 4'h3));
        check("irq_clr", {31'd0, irq}, 32'd0);
        run_vec(1003, wr(2'd0, 32'hC, 2'd0, 32'hC, 4'hC));
`endif

        // Reset mid-countdown: immediate RESET_VALUE, countdown abandoned
        run_vec(2000, wr(2'd2, 32'd3, 2'd2, 32'd3, 4'hC));
        #2;
        reset_n = 1'b0;
        bus.address = 2'd2;
        #1;
        check("rst_async_out", {28'd0, out_port}, 32'h1);
        check("rst_async_count", bus.readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.address = 2'd3;
        #1;
        check("rst_no_toggle_out", {28'd0, out_port}, 32'h1);
        check("rst_no_toggle_status", bus.readdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
